// File: rtl/byte_stream_packer.sv
// Byte-lane stream packer: gathers LANES-byte beats into a SIZE_IN_BYTES-byte
// word (sequential or addressed placement), tracks which bytes were written,
// and hands finished words to a one-word valid/ready output buffer so the
// next word can be assembled while the current one drains.
module byte_stream_packer #(
    parameter int SIZE_IN_BYTES = 12,
    parameter int BYTE_NUM_SIZE = 16,
    parameter int LANES         = 1
) (
    input  logic                       CLK,
    input  logic                       ARESET,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [LANES*8-1:0]         IN_DATA,
    input  logic                       IN_MODE,
    input  logic [BYTE_NUM_SIZE-1:0]   IN_BYTE_NUM,
    input  logic                       IN_LAST,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [SIZE_IN_BYTES*8-1:0] OUT_VALUE,
    output logic [SIZE_IN_BYTES-1:0]   OUT_BYTE_MASK,
    output logic                       ERR_RANGE
);

    localparam int PTR_W = $clog2(SIZE_IN_BYTES + 1);
    // One extra bit so base + LANES never wraps (LANES <= SIZE < 2**BYTE_NUM_SIZE).
    localparam int BW = BYTE_NUM_SIZE + 1;
    localparam logic [BW-1:0] SIZE_W  = BW'(SIZE_IN_BYTES);
    localparam logic [BW-1:0] LANES_W = BW'(LANES);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                     state_reg, state_next;
    logic [SIZE_IN_BYTES*8-1:0] asm_reg, asm_next;
    logic [SIZE_IN_BYTES-1:0]   amask_reg, amask_next;
    logic [PTR_W-1:0]           ptr_reg, ptr_next;
    logic [SIZE_IN_BYTES*8-1:0] out_value_reg, out_value_next;
    logic [SIZE_IN_BYTES-1:0]   out_mask_reg, out_mask_next;
    logic                       out_valid_reg, out_valid_next;
    logic                       err_reg, err_next;

    logic [BW-1:0]              base;
    logic [BW-1:0]              end_idx;
    logic                       overflow;
    logic                       commit_beat;
    logic                       accept;
    logic                       can_xfer;
    logic [SIZE_IN_BYTES*8-1:0] merged_word;
    logic [SIZE_IN_BYTES-1:0]   merged_mask;

    assign IN_READY      = (state_reg == FILL) && !ARESET;
    assign OUT_VALID     = out_valid_reg;
    assign OUT_VALUE     = out_value_reg;
    assign OUT_BYTE_MASK = out_mask_reg;
    assign ERR_RANGE     = err_reg;

    assign accept   = IN_VALID && IN_READY;
    assign can_xfer = !out_valid_reg || OUT_READY;

    // Byte index of lane 0, the index just past the last lane, and whether any lane falls off the word.
    assign base        = IN_MODE ? {1'b0, IN_BYTE_NUM} : BW'(ptr_reg);
    assign end_idx     = base + LANES_W;
    assign overflow    = end_idx > SIZE_W;
    assign commit_beat = IN_LAST || (!IN_MODE && (end_idx == SIZE_W));

    // Per output byte: pick the lane that lands on it (if any), else keep the assembled byte.
    genvar gi;
    generate
        for (gi = 0; gi < SIZE_IN_BYTES; gi++) begin : g_byte
            logic [7:0] byte_val;
            logic       byte_hit;

            // Lane-to-byte steering for this byte position.
            always_comb begin
                byte_val = asm_reg[gi*8 +: 8];
                byte_hit = 1'b0;
                for (int k = 0; k < LANES; k++) begin
                    if (base + BW'(k) == BW'(gi)) begin
                        byte_val = IN_DATA[k*8 +: 8];
                        byte_hit = 1'b1;
                    end
                end
            end

            assign merged_word[gi*8 +: 8] = byte_val;
            assign merged_mask[gi]        = amask_reg[gi] | byte_hit;
        end
    endgenerate

    // Next-state: assembly, commit to the output buffer, and drain handling.
    always_comb begin
        state_next     = state_reg;
        asm_next       = asm_reg;
        amask_next     = amask_reg;
        ptr_next       = ptr_reg;
        out_value_next = out_value_reg;
        out_mask_next  = out_mask_reg;
        out_valid_next = out_valid_reg && !OUT_READY;
        err_next       = err_reg;

        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (overflow) begin
                        err_next = 1'b1;
                    end
                    if (commit_beat) begin
                        if (can_xfer) begin
                            out_value_next = merged_word;
                            out_mask_next  = merged_mask;
                            out_valid_next = 1'b1;
                            asm_next       = '0;
                            amask_next     = '0;
                        end else begin
                            // Buffer still occupied: park the finished word in the assembly registers.
                            asm_next   = merged_word;
                            amask_next = merged_mask;
                            state_next = HOLD;
                        end
                        ptr_next = '0;
                    end else begin
                        asm_next   = merged_word;
                        amask_next = merged_mask;
                        ptr_next   = overflow ? PTR_W'(SIZE_W) : PTR_W'(end_idx);
                    end
                end
            end
            HOLD: begin
                if (can_xfer) begin
                    out_value_next = asm_reg;
                    out_mask_next  = amask_reg;
                    out_valid_next = 1'b1;
                    asm_next       = '0;
                    amask_next     = '0;
                    ptr_next       = '0;
                    state_next     = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // State registers with synchronous reset that discards any partial or pending word.
    always_ff @(posedge CLK) begin
        if (ARESET) begin
            state_reg     <= FILL;
            asm_reg       <= '0;
            amask_reg     <= '0;
            ptr_reg       <= '0;
            out_value_reg <= '0;
            out_mask_reg  <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            asm_reg       <= asm_next;
            amask_reg     <= amask_next;
            ptr_reg       <= ptr_next;
            out_value_reg <= out_value_next;
            out_mask_reg  <= out_mask_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
        end
    end

endmodule
